// File: rtl/clock12_pkg.sv
// Shared types, reset constants and counter limits for the 12-hour BCD clock.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package clock12_pkg;

  // One BCD digit and a two-digit BCD value (tens in the upper nibble)
  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd2_t;

  // Reset time is 12:00:00 AM
  localparam bcd2_t RST_HR  = 8'h12;
  localparam bcd2_t RST_MIN = 8'h00;
  localparam bcd2_t RST_SEC = 8'h00;

  // Counter limits; hours run 12,01..11 so the low limit is 01 and the high 12
  localparam bcd2_t HR_LO   = 8'h01;
  localparam bcd2_t HR_HI   = 8'h12;
  localparam bcd2_t MIN_LO  = 8'h00;
  localparam bcd2_t MIN_HI  = 8'h59;
  localparam bcd2_t SEC_LO  = 8'h00;
  localparam bcd2_t SEC_HI  = 8'h59;

  // The hour value whose increment flips AM/PM (11 -> 12)
  localparam bcd2_t HR_PM_FLIP = 8'h11;

  // Next value of a two-digit BCD counter bounded by [lo, hi]
  function automatic bcd2_t bcd2_step(input bcd2_t v, input bcd2_t lo, input bcd2_t hi);
    bcd2_t n;
    n = v;
    if (v == hi) begin
      n = lo;
    end else if (v.ones == 4'd9) begin
      n.tens = v.tens + 4'd1;
      n.ones = 4'd0;
    end else begin
      n.ones = v.ones + 4'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/clock12_bcd_counter.sv
// Two-digit BCD counter bounded by LO..HI with increment, clear and wrap-carry out.
// Latency: value updates 1 cycle after inc; wrap is combinational (inc while at HI).
// Backpressure: none; inc is acted on every cycle it is high.
module clock12_bcd_counter
  import clock12_pkg::*;
#(
  parameter bcd2_t LO      = 8'h00,
  parameter bcd2_t HI      = 8'h59,
  parameter bcd2_t RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value,
  output logic       wrap
);

  bcd2_t cnt;

  // Count register: reset/clear load RST_VAL, inc steps within LO..HI
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= RST_VAL;
    end else if (inc) begin
      cnt <= bcd2_step(cnt, LO, HI);
    end
  end

  assign value = cnt;
  assign wrap  = inc && (cnt == HI);

endmodule

// File: rtl/clock12_core.sv
// 12-hour BCD time-of-day clock with set mode; optional alarm when CLOCK12_ALARM_EN is defined.
// Latency: time and sec_pulse update 1 cycle after prescaler wrap; alarm 1 cycle after match.
// Backpressure: none; all inputs are sampled every cycle and nothing stalls.
module clock12_core
  import clock12_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_mode,
  input  logic       inc_hr,
  input  logic       inc_min,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm,
  output logic       sec_pulse
`ifdef CLOCK12_ALARM_EN
  ,
  input  logic [7:0] alarm_hr,
  input  logic [7:0] alarm_min,
  input  logic [0:0] alarm_pm,
  output logic [0:0] alarm
`endif
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  logic [PW-1:0] presc;
  logic          sec_event;
  logic          sec_wrap;
  logic          min_wrap;
  logic          hr_wrap;
  logic          min_inc;
  logic          hr_inc;

  // Prescaler: held at 0 in set mode so run mode always starts a full second
  always_ff @(posedge clk) begin
    if (rst || set_mode) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_ONE;
    end
  end

  assign sec_event = !set_mode && (presc == PRESC_LAST);

  // In set mode the buttons drive minutes/hours and carries are cut;
  // in run mode the buttons are ignored and only carries advance the time.
  assign min_inc = set_mode ? inc_min : sec_wrap;
  assign hr_inc  = set_mode ? inc_hr  : min_wrap;

  clock12_bcd_counter #(
    .LO      (SEC_LO),
    .HI      (SEC_HI),
    .RST_VAL (RST_SEC)
  ) u_sec (
    .clk   (clk),
    .rst   (rst),
    .clr   (set_mode),
    .inc   (sec_event),
    .value (sec_bcd),
    .wrap  (sec_wrap)
  );

  clock12_bcd_counter #(
    .LO      (MIN_LO),
    .HI      (MIN_HI),
    .RST_VAL (RST_MIN)
  ) u_min (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (min_inc),
    .value (min_bcd),
    .wrap  (min_wrap)
  );

  clock12_bcd_counter #(
    .LO      (HR_LO),
    .HI      (HR_HI),
    .RST_VAL (RST_HR)
  ) u_hr (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (hr_inc),
    .value (hr_bcd),
    .wrap  (hr_wrap)
  );

  // AM/PM flips only on 11 -> 12, not on the 12 -> 01 counter wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      pm <= 1'b0;
    end else if (hr_inc && (hr_bcd == HR_PM_FLIP)) begin
      pm <= ~pm;
    end
  end

  // One-cycle strobe aligned with the run-mode seconds update
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_pulse <= 1'b0;
    end else begin
      sec_pulse <= sec_event;
    end
  end

`ifdef CLOCK12_ALARM_EN
  // Alarm follows a registered compare of the displayed time, run mode only
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm <= 1'b0;
    end else begin
      alarm <= {!set_mode && (hr_bcd == alarm_hr) && (min_bcd == alarm_min) && (pm == alarm_pm[0])};
    end
  end
`endif

endmodule

// File: tb/tb_clock12_core.sv
// Directed bench for clock12_core with TICKS_PER_SEC=4; alarm steps included when CLOCK12_ALARM_EN is defined.
// Latency: n/a.
// Backpressure: n/a.
module tb_clock12_core;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_mode;
  logic       inc_hr;
  logic       inc_min;
  logic [7:0] hr_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       pm;
  logic       sec_pulse;
`ifdef CLOCK12_ALARM_EN
  logic [7:0] alarm_hr;
  logic [7:0] alarm_min;
  logic [0:0] alarm_pm;
  logic [0:0] alarm;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clock12_core #(.TICKS_PER_SEC(TPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .set_mode  (set_mode),
    .inc_hr    (inc_hr),
    .inc_min   (inc_min),
    .hr_bcd    (hr_bcd),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .pm        (pm),
    .sec_pulse (sec_pulse)
`ifdef CLOCK12_ALARM_EN
    ,
    .alarm_hr  (alarm_hr),
    .alarm_min (alarm_min),
    .alarm_pm  (alarm_pm),
    .alarm     (alarm)
`endif
  );

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s, input logic p, input logic sp);
    chk({tag, ".hr"},  hr_bcd,  h);
    chk({tag, ".min"}, min_bcd, m);
    chk({tag, ".sec"}, sec_bcd, s);
    chk({tag, ".pm"},  {7'd0, pm},  {7'd0, p});
    chk({tag, ".sp"},  {7'd0, sec_pulse}, {7'd0, sp});
  endtask

  initial begin
    rst      = 1'b1;
    set_mode = 1'b0;
    inc_hr   = 1'b0;
    inc_min  = 1'b0;
`ifdef CLOCK12_ALARM_EN
    alarm_hr  = 8'h07;
    alarm_min = 8'h33;
    alarm_pm  = 1'b1;
`endif

    // Reset for one cycle, then first second after four clocks
    tick(1);
    rst = 1'b0;
    chk_time("reset", 8'h12, 8'h00, 8'h00, 1'b0, 1'b0);
    tick(3);
    chk_time("pre_first_sec", 8'h12, 8'h00, 8'h00, 1'b0, 1'b0);
    tick(1);
    chk_time("first_sec", 8'h12, 8'h00, 8'h01, 1'b0, 1'b1);
    tick(1);
    chk_time("pulse_one_cycle", 8'h12, 8'h00, 8'h01, 1'b0, 1'b0);

    // Set 11:59 AM: seconds forced to 00 in set mode
    set_mode = 1'b1;
    inc_min  = 1'b1;
    tick(59);
    inc_min  = 1'b0;
    inc_hr   = 1'b1;
    tick(11);
    inc_hr   = 1'b0;
    tick(1);
    chk_time("set_1159am", 8'h11, 8'h59, 8'h00, 1'b0, 1'b0);

    // Run 59 s with buttons held: buttons must be ignored
    set_mode = 1'b0;
    inc_hr   = 1'b1;
    inc_min  = 1'b1;
    tick(59 * TPS);
    inc_hr   = 1'b0;
    inc_min  = 1'b0;
    chk_time("run_115959", 8'h11, 8'h59, 8'h59, 1'b0, 1'b1);
    tick(TPS);
    chk_time("noon_pm", 8'h12, 8'h00, 8'h00, 1'b1, 1'b1);

    // Set 12:59 PM, roll over to 01:00:00 PM without pm change
    set_mode = 1'b1;
    inc_min  = 1'b1;
    tick(59);
    inc_min  = 1'b0;
    tick(1);
    chk_time("set_1259pm", 8'h12, 8'h59, 8'h00, 1'b1, 1'b0);
    set_mode = 1'b0;
    tick(59 * TPS);
    chk_time("run_125959", 8'h12, 8'h59, 8'h59, 1'b1, 1'b1);
    tick(TPS);
    chk_time("one_pm", 8'h01, 8'h00, 8'h00, 1'b1, 1'b1);

    // From 01:00 PM reach 11:59 AM: hours 22 steps, minutes 59, overlapping
    set_mode = 1'b1;
    inc_hr   = 1'b1;
    inc_min  = 1'b1;
    tick(22);
    inc_hr   = 1'b0;
    tick(37);
    inc_min  = 1'b0;
    tick(1);
    chk_time("set_1159am_b", 8'h11, 8'h59, 8'h00, 1'b0, 1'b0);
    // Both buttons in one cycle: 12:00 PM, minutes wrap without carry
    inc_hr  = 1'b1;
    inc_min = 1'b1;
    tick(1);
    inc_hr  = 1'b0;
    inc_min = 1'b0;
    chk_time("both_inc", 8'h12, 8'h00, 8'h00, 1'b1, 1'b0);
    tick(10);
    chk_time("set_hold", 8'h12, 8'h00, 8'h00, 1'b1, 1'b0);

    // Reach 05:37:42 PM with prescaler at 2, then reset mid-count
    inc_hr = 1'b1;
    tick(5);
    inc_hr  = 1'b0;
    inc_min = 1'b1;
    tick(37);
    inc_min  = 1'b0;
    set_mode = 1'b0;
    tick(42 * TPS);
    chk_time("run_053742", 8'h05, 8'h37, 8'h42, 1'b1, 1'b1);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_time("mid_reset", 8'h12, 8'h00, 8'h00, 1'b0, 1'b0);
`ifdef CLOCK12_ALARM_EN
    chk("mid_reset.alarm", {7'd0, alarm}, 8'h00);
`endif
    tick(3);
    chk_time("post_rst_wait", 8'h12, 8'h00, 8'h00, 1'b0, 1'b0);
    tick(1);
    chk_time("post_rst_sec", 8'h12, 8'h00, 8'h01, 1'b0, 1'b1);

`ifdef CLOCK12_ALARM_EN
    // Alarm at 12:01 AM from a fresh reset
    alarm_hr  = 8'h12;
    alarm_min = 8'h01;
    alarm_pm  = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("alarm_after_rst", {7'd0, alarm}, 8'h00);
    tick(60 * TPS);
    chk("alarm_min01", min_bcd, 8'h01);
    chk("alarm_not_yet", {7'd0, alarm}, 8'h00);
    tick(1);
    chk("alarm_rise", {7'd0, alarm}, 8'h01);
    tick(60 * TPS - 1);
    chk("alarm_min02", min_bcd, 8'h02);
    chk("alarm_still", {7'd0, alarm}, 8'h01);
    tick(1);
    chk("alarm_fall", {7'd0, alarm}, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock12_core.md
CLOCK12_CORE -- requirements
Module: clock12_core

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 10000000, giving clk cycles per second (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port set_mode, input, 1; 1 puts the block in time-set mode and 0 selects run mode.
REQ-005 SHALL have port inc_hr, input, 1; a one-cycle pulse that increments hours, used in set mode.
REQ-006 SHALL have port inc_min, input, 1; a one-cycle pulse that increments minutes, used in set mode.
REQ-007 SHALL have port hr_bcd, output, 8; hours as two BCD digits, range 01..12.
REQ-008 SHALL have port min_bcd, output, 8; minutes as two BCD digits, range 00..59.
REQ-009 SHALL have port sec_bcd, output, 8; seconds as two BCD digits, range 00..59.
REQ-010 SHALL have port pm, output, 1; 0 means AM and 1 means PM.
REQ-011 SHALL have port sec_pulse, output, 1; it is high for one cycle in the first cycle that a run-mode second advance is visible.

Function
REQ-012 SHALL contain a prescaler that counts 0..TICKS_PER_SEC-1 and wraps; the wrap cycle is the "second event".
REQ-013 SHALL, on a second event in run mode, advance seconds 00..59 and wrap; the 59->00 step carries into minutes.
REQ-014 SHALL advance minutes 00..59 and wrap; the 59->00 step carries into hours.
REQ-015 SHALL step hours 12,01,02..11,12; only the 11->12 transition toggles pm.
REQ-016 SHALL make every output registered, with time and sec_pulse updated on the same edge (latency 1 cycle from the prescaler wrap).
REQ-017 SHALL, while set_mode=1, hold the prescaler and seconds at 0, keep sec_pulse at 0, and never carry.
REQ-018 SHALL, in set mode, make inc_min increment minutes with wrap (59->00) and no carry into hours.
REQ-019 SHALL, in set mode, make inc_hr step hours per REQ-015, including the pm toggle at 11->12.
REQ-020 SHALL apply inc_hr and inc_min independently when both are high in the same cycle.
REQ-021 SHALL ignore inc_hr and inc_min while set_mode=0.
REQ-022 SHALL restart the prescaler at 0 on the 1->0 edge of set_mode; the first sec_pulse follows TICKS_PER_SEC cycles later.
REQ-023 SHALL never produce invalid BCD (digit >9, hours 00 or >12), including at every wrap point.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, set hr_bcd=8'h12, min_bcd=8'h00, sec_bcd=8'h00, pm=0, sec_pulse=0, prescaler=0 and alarm=0, overriding all other inputs.
REQ-025 SHALL apply reset taken mid-count or in set mode with the same values, visible the cycle after the edge.

Configuration
REQ-026 SHALL, when macro CLOCK12_ALARM_EN is defined, add inputs alarm_hr[7:0] (BCD), alarm_min[7:0] (BCD) and alarm_pm[0:0], plus output alarm[0:0].
REQ-027 SHALL, with CLOCK12_ALARM_EN defined, register alarm high while set_mode=0 and hr_bcd/min_bcd/pm equal the alarm inputs, with 1-cycle latency and a low output otherwise.
REQ-028 SHALL, without CLOCK12_ALARM_EN, omit the alarm ports and logic entirely; all other behaviour is identical.

Structure
REQ-029 SHALL take from shared package clock12_pkg: the BCD digit type, the reset time constants (12:00:00 AM), and the hour/minute/second limits.
REQ-030 SHALL instantiate sub-module clock12_bcd_counter (two-digit BCD counter with min/max limits, inc, wrap-carry out) for seconds, minutes and hours.

Verification
REQ-031 SHALL verify, with TICKS_PER_SEC=4: rst for 1 cycle, then run -> 12:00:00 AM, and sec_pulse with sec_bcd=8'h01 in cycle 4 after release.
REQ-032 SHALL verify: set 11:59 AM, run 59 s to 11:59:59 -> next second gives 12:00:00 with pm=1.
REQ-033 SHALL verify: set 12:59 PM, run to 12:59:59 -> next second gives 01:00:00 with pm still 1.
REQ-034 SHALL verify: set_mode=1 with min=59 and hr=11 AM, inc_hr and inc_min in the same cycle -> 12:00 PM, sec_bcd=00, no sec_pulse.
REQ-035 SHALL verify: rst asserted at 05:37:42 PM with prescaler=2 -> 12:00:00 AM next cycle, and the next sec_pulse 4 cycles after release.
REQ-036 SHALL verify, with CLOCK12_ALARM_EN: alarm set to 12:01 AM, run from reset -> alarm rises 1 cycle after min_bcd=8'h01 and falls 1 cycle after min_bcd=8'h02.
